mem_access_unit: RTL and testbench

- Initiator/master for the word-organised data RAM; it drives the RAM's write_enable/address/in port and reads its combinational out port.
- Converts CPU byte/halfword/word load and store requests (RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW semantics) into word-granular RAM cycles.
- Uses read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Sits between the pipeline's MEM stage and the RAM.

---
 rtl/mem_access_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Word-granular RAM master for RISC-V byte/half/word loads and stores (RMW for sub-word stores).
// Define MEM_MISALIGNED_SPLIT_EN to split misaligned accesses that straddle two words.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [3:0] {
        StIdle,
        StAccess,
        StWrite,
        StAccessLo,
        StAccessHi,
        StRdLo,
        StRdHi,
        StWrLo,
        StWrHi
    } state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
`ifdef MEM_MISALIGNED_SPLIT_EN
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           hi_q, hi_d;
`endif

    logic                  accept;
    logic                  misaligned;
    logic                  spans;
    logic                  bad_req;
    logic [ADDR_WIDTH-1:0] req_base;

    // Select the addressed lane of a (possibly two-word) little-endian window and extend it.
    function automatic logic [31:0] extract(input logic [63:0] dw, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] w;
        w = 32'(dw >> {off, 3'b000});
        case (size)
            2'd0:    extract = uns ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'd1:    extract = uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] dw, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] size);
        logic [63:0] mask;
        logic [63:0] data;
        case (size)
            2'd0:    mask = 64'h0000_0000_0000_00ff;
            2'd1:    mask = 64'h0000_0000_0000_ffff;
            default: mask = 64'h0000_0000_ffff_ffff;
        endcase
        mask  = mask << {off, 3'b000};
        data  = {32'b0, wd} << {off, 3'b000};
        merge = (dw & ~mask) | (data & mask);
    endfunction

    assign req_ready  = (state_q == StIdle) && !reset;
    assign accept     = req_valid && req_ready;
    assign req_base   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    // A half at offset 1 is misaligned but still lives inside one word.
    assign spans      = ((req_size == 2'd1) && (req_addr[1:0] == 2'b11)) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`ifdef MEM_MISALIGNED_SPLIT_EN
    assign bad_req    = (req_size == 2'd3);
`else
    assign bad_req    = (req_size == 2'd3) || misaligned;
`endif

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
`ifdef MEM_MISALIGNED_SPLIT_EN
        lo_d         = lo_q;
        hi_d         = hi_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    base_d  = req_base;
                    wdata_d = req_wdata;
                    if (bad_req) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'b0;
`ifdef MEM_MISALIGNED_SPLIT_EN
                    end else if (spans) begin
                        ram_addr_d = req_base;
                        state_d    = req_write ? StRdLo : StAccessLo;
`endif
                    end else begin
                        ram_addr_d = req_base;
                        state_d    = StAccess;
                        if (req_write && (req_size == 2'd2)) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = req_wdata;
                        end
                    end
                end
            end
            StAccess: begin
                if (write_q && (size_q != 2'd2)) begin
                    ram_we_d    = 1'b1;
                    ram_wdata_d = 32'(merge({32'b0, ram_rdata}, wdata_q, off_q, size_q));
                    state_d     = StWrite;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = write_q ? 32'b0 : extract({32'b0, ram_rdata}, off_q, size_q,
                                                             uns_q);
                    state_d      = StIdle;
                end
            end
            StWrite: begin
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'b0;
                state_d      = StIdle;
            end
`ifdef MEM_MISALIGNED_SPLIT_EN
            StAccessLo: begin
                lo_d       = ram_rdata;
                ram_addr_d = base_q + ADDR_WIDTH'(4);
                state_d    = StAccessHi;
            end
            StAccessHi: begin
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = extract({ram_rdata, lo_q}, off_q, size_q, uns_q);
                state_d      = StIdle;
            end
            StRdLo: begin
                lo_d       = ram_rdata;
                ram_addr_d = base_q + ADDR_WIDTH'(4);
                state_d    = StRdHi;
            end
            StRdHi: begin
                {hi_d, ram_wdata_d} = merge({ram_rdata, lo_q}, wdata_q, off_q, size_q);
                ram_we_d            = 1'b1;
                ram_addr_d          = base_q;
                state_d             = StWrLo;
            end
            StWrLo: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = base_q + ADDR_WIDTH'(4);
                ram_wdata_d = hi_q;
                state_d     = StWrHi;
            end
            StWrHi: begin
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'b0;
                state_d      = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= 2'b0;
            uns_q        <= 1'b0;
            off_q        <= 2'b0;
            base_q       <= '0;
            wdata_q      <= 32'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_error_q <= 1'b0;
`ifdef MEM_MISALIGNED_SPLIT_EN
            lo_q         <= 32'b0;
            hi_q         <= 32'b0;
`endif
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
`ifdef MEM_MISALIGNED_SPLIT_EN
            lo_q         <= lo_d;
            hi_q         <= hi_d;
`endif
        end
    end

    // Gate with reset so a write in flight when reset rises never reaches the RAM.
    assign ram_we     = ram_we_q && !reset;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a byte-addressed memory model.
module tb_mem_access_unit;

    localparam int unsigned AW = 16;
`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    logic [31:0] last_wdata = 32'b0;

    logic [31:0] ram     [0:16383];
    logic [7:0]  ref_mem [0:65535];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    assign ram_rdata = ram[ram_addr[15:2]];

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr[15:2]] <= ram_wdata;
            last_wdata          <= ram_wdata;
            we_cnt              <= we_cnt + 1;
            check("ram_addr_aligned", {30'b0, ram_addr[1:0]}, 32'b0);
        end
    end

    // Reference: plain byte memory, little-endian, updated as each request is issued.
    task automatic model(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int nwr);
        int  n;
        bit  mis, span;
        n    = 1 << size;
        mis  = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        span = (int'(addr[1:0]) + n) > 4;
        err  = (size == 2'd3) || (mis && !SPLIT);
        rdata = 32'b0;
        nwr   = 0;
        if (err) begin
            lat = 1;
        end else if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[addr + 16'(i)] = wdata[8*i +: 8];
            nwr = span ? 2 : 1;
            lat = span ? 5 : ((size == 2'd2) ? 2 : 3);
        end else begin
            for (int i = 0; i < n; i++) rdata[8*i +: 8] = ref_mem[addr + 16'(i)];
            if (!uns && size == 2'd0) rdata = {{24{rdata[7]}}, rdata[7:0]};
            if (!uns && size == 2'd1) rdata = {{16{rdata[15]}}, rdata[15:0]};
            lat = span ? 3 : 2;
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_nwr, lat, w, start;
        string       tag;
        tag = $sformatf("%s%0d@%h", wr ? "st" : "ld", size, addr);
        model(wr, size, uns, addr, wdata, e_err, e_rd, e_lat, e_nwr);
        @(negedge clk);
        drive(wr, size, uns, addr, wdata);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        start = we_cnt;
        #1;
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = $urandom;
        req_size  = 2'($urandom);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " error"}, {31'b0, resp_error}, {31'b0, e_err});
        check({tag, " rdata"}, resp_rdata, e_rd);
        check({tag, " writes"}, 32'(we_cnt - start), 32'(e_nwr));
        check({tag, " ready_in_resp"}, {31'b0, req_ready}, 32'd1);
        rd = resp_rdata;
        @(posedge clk);
        #1;
        check({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e_err;
        logic [31:0] e_rda, e_rdb;
        int          e_lat, e_nwr, start;

        for (int i = 0; i < 16384; i++) ram[i] = 32'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'b0;
        reset = 1'b1;
        req_valid = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        check("rst ram_we", {31'b0, ram_we}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_error", {31'b0, resp_error}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst ram_addr", {16'b0, ram_addr}, 32'd0);
        check("rst ram_wdata", ram_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Directed sequence
        do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, rd);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd);
        check("lw_10", rd, 32'hDEADBEEF);
        do_req(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, rd);
        check("lb_13", rd, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, rd);
        check("lbu_13", rd, 32'h000000DE);
        do_req(1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, rd);
        check("lh_10", rd, 32'hFFFFBEEF);
        do_req(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, rd);
        check("lhu_12", rd, 32'h0000DEAD);
        do_req(1'b1, 2'd0, 1'b0, 16'h0011, 32'h00000055, rd);
        check("sb_merge", last_wdata, 32'hDEAD55EF);
        do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd);
        check("lw_after_sb", rd, 32'hDEAD55EF);
        do_req(1'b0, 2'd2, 1'b0, 16'h0012, 32'h0, rd);
        do_req(1'b1, 2'd1, 1'b0, 16'h0013, 32'h0000CAFE, rd);
        do_req(1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, rd);
        do_req(1'b1, 2'd3, 1'b0, 16'h0014, 32'h12345678, rd);
        do_req(1'b1, 2'd2, 1'b0, 16'h0020, 32'h11223344, rd);
        do_req(1'b1, 2'd2, 1'b0, 16'h0024, 32'h55667788, rd);
        do_req(1'b0, 2'd2, 1'b0, 16'h0022, 32'h0, rd);
        if (SPLIT) check("lw_22_split", rd, 32'h77881122);
        do_req(1'b1, 2'd2, 1'b0, 16'hFFFC, 32'hAABBCCDD, rd);
        do_req(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h01020304, rd);
        do_req(1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0, rd);
        do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0, rd);

        // Back-to-back loads with req_valid held high
        model(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, e_err, e_rda, e_lat, e_nwr);
        model(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, e_err, e_rdb, e_lat, e_nwr);
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        @(posedge clk);
        #1;
        req_addr = 16'h0020;
        @(posedge clk);
        #1;
        check("b2b first valid", {31'b0, resp_valid}, 32'd1);
        check("b2b first rdata", resp_rdata, e_rda);
        check("b2b ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b gap", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("b2b second valid", {31'b0, resp_valid}, 32'd1);
        check("b2b second rdata", resp_rdata, e_rdb);
        @(posedge clk);

        // Reset during the WRITE cycle of a byte store: nothing may reach the RAM
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 16'h0012, 32'h000000A5);
        @(posedge clk);
        start = we_cnt;
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort in_write", {31'b0, ram_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort we_gated", {31'b0, ram_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("abort no_resp", {31'b0, resp_valid}, 32'd0);
            check("abort ready", {31'b0, req_ready}, 32'd1);
            @(posedge clk);
        end
        check("abort no_write", 32'(we_cnt - start), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd);

        // Randomised traffic around a small window and the top of the address space
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 4) != 0) ? 16'($urandom_range(0, 47))
                                            : 16'hFFF0 + 16'($urandom_range(0, 15));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
